hex_share_arbiter: RTL

- Shares one 7-segment hex digit between N_REQ requesters, each presenting a 4-bit value.
- Round-robin arbiter grants the digit for a fixed dwell, then blanks it for a fixed gap, then re-arbitrates.
- Drives active-low segments directly: bit0=a … bit6=g, 0 = segment lit.
- Sits between status/debug producers and the board's hex digit pins.

---
 rtl/hex_share_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/hex_share_arbiter.sv
// rtl/hex_share_arbiter.sv - round-robin sharing of one active-low 7-segment hex digit
module hex_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int DWELL = 8,
  parameter int GAP   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   nibble,
  output logic [6:0]           hex,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 busy
);

  localparam int MAXC = (DWELL > GAP) ? ((DWELL > 2) ? DWELL : 2) : ((GAP > 2) ? GAP : 2);
  localparam int CW = $clog2(MAXC);
  localparam int PW = $clog2(N_REQ);
  localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

  state_t           r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_own;
  logic [CW-1:0]    r_cnt;
  logic [6:0]       r_hex;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_done;

  logic [PW-1:0]    w_nptr;
  logic [PW-1:0]    w_base;
  logic [PW-1:0]    w_win;
  logic [3:0]       w_nib;
  logic             w_found;
  logic             w_show_end;
  logic             w_arb;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  assign w_nptr     = (r_own == PW'(N_REQ - 1)) ? '0 : r_own + 1'b1;
  assign w_show_end = (r_state == S_SHOW) && (r_cnt == '0);
  // With GAP=0 the search at the end of a dwell must already start past the old owner
  assign w_base     = (r_state == S_SHOW) ? w_nptr : r_ptr;
  assign w_arb      = (r_state == S_IDLE) ||
                      ((r_state == S_GAP) && (r_cnt == '0)) ||
                      (w_show_end && (GAP == 0));

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_nib   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && req[(int'(w_base) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_win   = PW'((int'(w_base) + k) % N_REQ);
        w_nib   = nibble[((int'(w_base) + k) % N_REQ) * 4 +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_own   <= '0;
      r_cnt   <= '0;
      r_hex   <= 7'h7F;
      r_grant <= '0;
      r_done  <= '0;
    end else begin
      r_done <= '0;
      if (w_show_end) begin
        r_done <= r_grant;
        r_ptr  <= w_nptr;
      end
      if (w_arb) begin
        if (w_found) begin
          r_state <= S_SHOW;
          r_own   <= w_win;
          r_grant <= N_REQ'(1) << w_win;
          r_hex   <= seg7(w_nib);
          r_cnt   <= DWELL_LD;
        end else begin
          r_state <= S_IDLE;
          r_grant <= '0;
          r_hex   <= 7'h7F;
          r_cnt   <= '0;
        end
      end else begin
        case (r_state)
          S_SHOW: begin
            if (r_cnt == '0) begin
              r_state <= S_GAP;
              r_cnt   <= GAP_LD;
              r_grant <= '0;
              r_hex   <= 7'h7F;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_GAP:   r_cnt <= r_cnt - 1'b1;
          default: r_cnt <= '0;
        endcase
      end
    end
  end

  assign hex   = r_hex;
  assign grant = r_grant;
  assign done  = r_done;
  assign busy  = (r_state != S_IDLE);

endmodule
